prog_loader: RTL and testbench



---
 rtl/prog_loader_if.sv | 31 +++
 rtl/prog_loader.sv | 194 +++++++++++++++++++
 tb/tb_prog_loader.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Byte-stream loader bundle: upstream byte handshake, clear, line-memory write port, start/status.
// Latency: n/a (signal bundle only).
// Backpressure: byte_ready from the loader side qualifies byte_valid from the source side.
// Ports: byte_valid/byte_data/clear driven by the source (master);
//        byte_ready, wr_en/wr_addr/wr_line, start, busy/done/err driven by the loader (slave).
interface prog_loader_if #(
    parameter int LINE_WIDTH = 16,
    parameter int IP_WIDTH   = 8
);
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic                  clear;
    logic                  wr_en;
    logic [IP_WIDTH-1:0]   wr_addr;
    logic [LINE_WIDTH-1:0] wr_line;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output byte_valid, byte_data, clear,
        input  byte_ready, wr_en, wr_addr, wr_line, start, busy, done, err
    );

    modport slave (
        input  byte_valid, byte_data, clear,
        output byte_ready, wr_en, wr_addr, wr_line, start, busy, done, err
    );
endinterface

// File: rtl/prog_loader.sv
// Program loader: takes a byte stream (line count N, then N lines MSB-first) and writes lines to memory.
// Latency: one WRITE cycle per line after its last byte; start pulses the cycle after the last write/check.
// Backpressure: byte_ready drops in WRITE/START/DONE/ERR; bytes offered then are held by the source.
// Ports: clk, rstn (async active-low); bus = prog_loader_if.slave (byte handshake, clear, write port,
//        start pulse, busy/done/err flags).
// Option: define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte (CHK state).
module prog_loader #(
    parameter int LINE_WIDTH = 16,
    parameter int IP_WIDTH   = 8
) (
    input logic          clk,
    input logic          rstn,
    prog_loader_if.slave bus
);
    localparam int BPL   = LINE_WIDTH / 8;
    localparam int BC_W  = (BPL > 1) ? $clog2(BPL) : 1;
    // Line count/counter need one extra bit: N may equal 2^IP_WIDTH.
    localparam int CNT_W = IP_WIDTH + 1;
    localparam int unsigned MAX_N = (IP_WIDTH >= 8) ? 32'd256 : (32'd1 << IP_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        WRITE,
`ifdef PROG_LOADER_CHECKSUM_EN
        CHK,
`endif
        START,
        DONE,
        ERR
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  byte_ready;
    logic                  accept;
    logic                  n_bad;
    logic                  last_byte;
    logic                  last_line;
    logic [CNT_W-1:0]      n_lines;
    logic [CNT_W-1:0]      line_cnt;
    logic [BC_W-1:0]       byte_cnt;
    logic [LINE_WIDTH-1:0] line_reg;
    logic                  wr_en_q;
    logic                  start_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]            csum;
`endif

    // byte_ready is a pure state decode.
    always_comb begin
        byte_ready = 1'b0;
        case (state)
            IDLE, DATA: byte_ready = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            CHK:        byte_ready = 1'b1;
`endif
            default:    byte_ready = 1'b0;
        endcase
    end

    assign accept    = bus.byte_valid & byte_ready;
    assign n_bad     = (bus.byte_data == 8'd0) || (32'(bus.byte_data) > MAX_N);
    assign last_byte = (byte_cnt == BC_W'(BPL - 1));
    assign last_line = ((line_cnt + CNT_W'(1)) == n_lines);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = n_bad ? ERR : DATA;
                end
            end
            DATA: begin
                if (accept && last_byte) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (last_line) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    state_nxt = CHK;
`else
                    state_nxt = START;
`endif
                end else begin
                    state_nxt = DATA;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CHK: begin
                if (accept) begin
                    state_nxt = (bus.byte_data == csum) ? START : ERR;
                end
            end
`endif
            START:   state_nxt = DONE;
            DONE:    state_nxt = DONE;
            ERR:     state_nxt = ERR;
            default: state_nxt = IDLE;
        endcase
        // Clear wins over everything, including a byte handshake this cycle.
        if (bus.clear) begin
            state_nxt = IDLE;
        end
    end

    // Flags are registered copies of the next state, so they line up with the state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_en_q <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            wr_en_q <= (state_nxt == WRITE);
            start_q <= (state_nxt == START);
            done_q  <= (state_nxt == DONE);
            err_q   <= (state_nxt == ERR);
            busy_q  <= (state_nxt != IDLE) && (state_nxt != DONE) && (state_nxt != ERR);
        end
    end

    // Datapath: line count, counters, line shift register and running checksum.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            n_lines  <= '0;
            line_cnt <= '0;
            byte_cnt <= '0;
            line_reg <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else if (bus.clear) begin
            n_lines  <= '0;
            line_cnt <= '0;
            byte_cnt <= '0;
            line_reg <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept && !n_bad) begin
                        n_lines  <= CNT_W'(bus.byte_data);
                        line_cnt <= '0;
                        byte_cnt <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        csum     <= '0;
`endif
                    end
                end
                DATA: begin
                    if (accept) begin
                        // Shift form keeps BPL == 1 legal (no negative slice).
                        line_reg <= (line_reg << 8) | LINE_WIDTH'(bus.byte_data);
                        byte_cnt <= last_byte ? '0 : byte_cnt + BC_W'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
                        csum     <= csum ^ bus.byte_data;
`endif
                    end
                end
                WRITE: begin
                    line_cnt <= line_cnt + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.byte_ready = byte_ready;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = line_cnt[IP_WIDTH-1:0];
    assign bus.wr_line    = line_reg;
    assign bus.start      = start_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: directed vectors plus random streams with random valid gaps,
// compared against a stream-level model of which lines get written and how the load ends.
`timescale 1ns/1ps
module tb_prog_loader;
    localparam int LINE_WIDTH = 16;
    localparam int IP_WIDTH   = 8;
    localparam int BPL        = LINE_WIDTH / 8;

    typedef logic [7:0] byte_q_t[$];

    logic clk = 1'b0;
    logic rstn;

    prog_loader_if #(.LINE_WIDTH(LINE_WIDTH), .IP_WIDTH(IP_WIDTH)) bus ();

    prog_loader #(.LINE_WIDTH(LINE_WIDTH), .IP_WIDTH(IP_WIDTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Monitor: cumulative log of writes and start-pulse cycles.
    logic [IP_WIDTH-1:0]   obs_addr[$];
    logic [LINE_WIDTH-1:0] obs_line[$];
    int                    obs_starts = 0;

    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (bus.wr_en) begin
                obs_addr.push_back(bus.wr_addr);
                obs_line.push_back(bus.wr_line);
            end
            if (bus.start) obs_starts++;
        end
    end

    // Reference model: what a stream should produce, from the loading rules alone.
    logic [IP_WIDTH-1:0]   exp_addr[$];
    logic [LINE_WIDTH-1:0] exp_line[$];
    int                    exp_starts;
    logic                  exp_done;
    logic                  exp_err;

    task automatic model(input byte_q_t s);
        int n;
        int idx;
        logic [7:0] x;
        logic [LINE_WIDTH-1:0] line;
        exp_addr.delete();
        exp_line.delete();
        exp_starts = 0;
        exp_done   = 1'b0;
        exp_err    = 1'b0;
        n = int'(s[0]);
        if (n == 0 || n > (1 << IP_WIDTH)) begin
            exp_err = 1'b1;
            return;
        end
        idx = 1;
        x   = 8'h00;
        for (int l = 0; l < n; l++) begin
            line = '0;
            for (int b = 0; b < BPL; b++) begin
                line = (line << 8) | LINE_WIDTH'(s[idx]);
                x    = x ^ s[idx];
                idx++;
            end
            exp_addr.push_back(IP_WIDTH'(l));
            exp_line.push_back(line);
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        if (s[idx] != x) begin
            exp_err = 1'b1;
            return;
        end
`endif
        exp_starts = 1;
        exp_done   = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge after acceptance (plus gap idle cycles).
    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        guard = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (!bus.byte_ready && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        chk("byte_ready_wait", 32'(bus.byte_ready), 32'd1);
        if (!bus.byte_ready) begin
            bus.byte_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        if (gap > 0) begin
            bus.byte_valid = 1'b0;
            repeat (gap) begin
                bus.byte_data = 8'($urandom);
                @(negedge clk);
            end
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'd1);
        chk({tag, "_wr_en"},      32'(bus.wr_en),      32'd0);
        chk({tag, "_wr_addr"},    32'(bus.wr_addr),    32'd0);
        chk({tag, "_wr_line"},    32'(bus.wr_line),    32'd0);
        chk({tag, "_start"},      32'(bus.start),      32'd0);
        chk({tag, "_busy"},       32'(bus.busy),       32'd0);
        chk({tag, "_done"},       32'(bus.done),       32'd0);
        chk({tag, "_err"},        32'(bus.err),        32'd0);
    endtask

    task automatic run_stream(input string tag, input byte_q_t s, input int max_gap);
        int wbase;
        int sbase;
        int guard;
        int nobs;
        model(s);
        wbase = obs_addr.size();
        sbase = obs_starts;
        foreach (s[i]) send_byte(s[i], $urandom_range(0, max_gap));
        bus.byte_valid = 1'b0;
        guard = 0;
        while (!(bus.done || bus.err) && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_finished"}, 32'(bus.done | bus.err), 32'd1);
        repeat (3) @(negedge clk);
        nobs = obs_addr.size() - wbase;
        chk({tag, "_nwrites"}, 32'(nobs), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < nobs; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 32'(obs_addr[wbase+i]), 32'(exp_addr[i]));
            chk($sformatf("%s_line%0d", tag, i), 32'(obs_line[wbase+i]), 32'(exp_line[i]));
        end
        chk({tag, "_starts"}, 32'(obs_starts - sbase), 32'(exp_starts));
        chk({tag, "_done"},   32'(bus.done), 32'(exp_done));
        chk({tag, "_err"},    32'(bus.err),  32'(exp_err));
        chk({tag, "_busy"},   32'(bus.busy), 32'd0);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        chk({tag, "_clr_flags"}, {29'd0, bus.done, bus.err, bus.busy}, 32'd0);
        chk({tag, "_clr_ready"}, 32'(bus.byte_ready), 32'd1);
    endtask

    function automatic byte_q_t rand_stream();
        byte_q_t s;
        int n;
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        if ($urandom_range(0, 7) == 0) begin
            s.push_back(8'h00);
            return s;
        end
        n = $urandom_range(1, 4);
        s.push_back(8'(n));
        for (int i = 0; i < n * BPL; i++) begin
            b = 8'($urandom);
            x = x ^ b;
            s.push_back(b);
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
        s.push_back(x);
`endif
        return s;
    endfunction

    byte_q_t s;
    int      wb;

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        bus.clear      = 1'b0;
        rstn           = 1'b0;
        #12;
        chk_idle("reset");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

`ifdef PROG_LOADER_CHECKSUM_EN
        s = '{8'h01, 8'h12, 8'h34, 8'h26};
        run_stream("csum_ok", s, 2);
        s = '{8'h01, 8'h12, 8'h34, 8'h27};
        run_stream("csum_bad", s, 2);
`else
        s = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        wb = obs_addr.size();
        run_stream("two_lines", s, 2);
        chk("two_lines_line0_const", 32'(obs_line[wb]),   32'h1234);
        chk("two_lines_line1_const", 32'(obs_line[wb+1]), 32'hABCD);
`endif

        // Zero line count: error one cycle after the byte, nothing written.
        s = '{8'h00};
        run_stream("zero_n", s, 0);

        // Clear mid-load, then a fresh load must restart at address 0.
        send_byte(8'h03, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 1);
        send_byte(8'h33, 0);
        bus.byte_valid = 1'b0;
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        chk("midclear_busy",  32'(bus.busy),       32'd0);
        chk("midclear_ready", 32'(bus.byte_ready), 32'd1);
        run_stream("after_clear", rand_stream(), 3);

        for (int k = 0; k < 12; k++) begin
            run_stream($sformatf("rand%0d", k), rand_stream(), 5);
        end

        // Async reset after three of four payload bytes.
        wb = obs_addr.size();
        send_byte(8'h02, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        bus.byte_valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk_idle("midreset");
        chk("midreset_nwrites", 32'(obs_addr.size() - wb), 32'd1);
        chk("midreset_line0",   32'(obs_line[wb]),         32'h1122);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        wb = obs_addr.size();
`ifdef PROG_LOADER_CHECKSUM_EN
        s = '{8'h01, 8'h55, 8'hAA, 8'hFF};
`else
        s = '{8'h01, 8'h55, 8'hAA};
`endif
        run_stream("post_reset", s, 3);
        chk("post_reset_addr_const", 32'(obs_addr[wb]), 32'd0);
        chk("post_reset_line_const", 32'(obs_line[wb]), 32'h55AA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
